// File: rtl/lvds_ddr_rx_align.sv
// LVDS DDR receive alignment for the AD9643 path.
// Demultiplexes IDDR rise/fall words into channel A/B samples (optional swap
// and offset-binary to two's-complement), and trains the IDELAY tap by sweeping
// it against the ADC test pattern, then parks it at the centre of the eye.
module lvds_ddr_rx_align #(
  parameter int                    DATA_WIDTH    = 14,
  parameter int                    TAP_WIDTH     = 5,
  parameter int                    SETTLE_CYCLES = 16,
  parameter int                    CHECK_LEN     = 256,
  parameter logic [DATA_WIDTH-1:0] PATTERN_RISE  = 14'h2AAA,
  parameter logic [DATA_WIDTH-1:0] PATTERN_FALL  = 14'h1555
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_rise,
  input  logic [DATA_WIDTH-1:0] data_fall,
  input  logic                  train_start,
  input  logic                  swap_ch,
  input  logic                  twos_comp,
  output logic [TAP_WIDTH-1:0]  tap_value,
  output logic                  tap_load,
  output logic [DATA_WIDTH-1:0] ch_a_data,
  output logic [DATA_WIDTH-1:0] ch_b_data,
  output logic                  data_valid,
  output logic                  locked,
  output logic                  train_fail,
  output logic                  busy
);

  localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_LEN) ? SETTLE_CYCLES : CHECK_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CHECK_LAST  = CNT_W'(CHECK_LEN - 1);
  localparam logic [TAP_WIDTH-1:0] TAP_MAX     = {TAP_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_CENTER, S_DONE, S_FAIL
  } state_e;

  state_e                 state_q;
  logic [TAP_WIDTH-1:0]   tap_q, first_q, last_q;
  logic                   tap_load_q, err_q, win_open_q, win_closed_q;
  logic                   locked_q, fail_q, busy_q, valid_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0]  ch_a_q, ch_b_q;

  logic [DATA_WIDTH-1:0]  ch_a_d, ch_b_d, msb_flip;
  logic                   mismatch;
  logic [TAP_WIDTH-1:0]   first_d, last_d, center_d;
  logic                   open_d, closed_d;
  logic [TAP_WIDTH:0]     tap_sum;

  // Sample selection/conversion, pattern compare and the window update EVAL commits
  always_comb begin
    // NOTE: every output of this block is assigned up front so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    msb_flip = {twos_comp, {(DATA_WIDTH-1){1'b0}}};
    ch_a_d   = (swap_ch ? data_fall : data_rise) ^ msb_flip;
    ch_b_d   = (swap_ch ? data_rise : data_fall) ^ msb_flip;
    // Raw words are compared: swap and format conversion never affect training
    mismatch = (data_rise != PATTERN_RISE) || (data_fall != PATTERN_FALL);

    first_d  = first_q;
    last_d   = last_q;
    open_d   = win_open_q;
    closed_d = win_closed_q;
    if (!err_q) begin
      if (!win_open_q) begin
        first_d = tap_q;
        open_d  = 1'b1;
      end
      last_d = tap_q;
    end else if (win_open_q) begin
      // Only the first contiguous good window counts
      closed_d = 1'b1;
    end
    // Extra bit keeps the sum exact before halving (floor)
    tap_sum  = {1'b0, first_d} + {1'b0, last_d};
    center_d = tap_sum[TAP_WIDTH:1];
  end

  // Registered datapath: one cycle latency, valid follows lock by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_a_q  <= '0;
      ch_b_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values, independent of statement order.
      ch_a_q  <= ch_a_d;
      ch_b_q  <= ch_b_d;
      valid_q <= locked_q;
    end
  end

  // Training FSM: tap sweep, window tracking and eye-centre parking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      tap_load_q   <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      first_q      <= '0;
      last_q       <= '0;
      win_open_q   <= 1'b0;
      win_closed_q <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // The load strobe is raised on entry to LOAD/CENTER and lasts one cycle
      tap_load_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (train_start) begin
            tap_q        <= '0;
            first_q      <= '0;
            last_q       <= '0;
            win_open_q   <= 1'b0;
            win_closed_q <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            busy_q       <= 1'b1;
            tap_load_q   <= 1'b1;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_q   <= '0;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_CHECK: begin
          err_q <= err_q | mismatch;
          if (cnt_q == CHECK_LAST) begin
            cnt_q   <= '0;
            state_q <= S_EVAL;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_EVAL: begin
          first_q      <= first_d;
          last_q       <= last_d;
          win_open_q   <= open_d;
          win_closed_q <= closed_d;
          tap_load_q   <= 1'b1;
          if (closed_d || (tap_q == TAP_MAX)) begin
            tap_q   <= open_d ? center_d : '0;
            state_q <= S_CENTER;
          end else begin
            tap_q   <= tap_q + TAP_WIDTH'(1);
            state_q <= S_LOAD;
          end
        end
        S_CENTER: begin
          busy_q <= 1'b0;
          if (win_open_q) begin
            locked_q <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            fail_q  <= 1'b1;
            state_q <= S_FAIL;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tap_value  = tap_q;
  assign tap_load   = tap_load_q;
  assign ch_a_data  = ch_a_q;
  assign ch_b_data  = ch_b_q;
  assign data_valid = valid_q;
  assign locked     = locked_q;
  assign train_fail = fail_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lvds_ddr_rx_align.sv
// Self-checking bench for lvds_ddr_rx_align: a behavioural eye model drives
// the pattern per tap, a sweep model predicts the tap_load sequence and the
// final centre, and a per-cycle compare process checks datapath and loads.
module tb_lvds_ddr_rx_align;

  localparam int DW         = 14;
  localparam int TW         = 5;
  localparam int SETTLE     = 4;
  localparam int CLEN       = 16;
  localparam int TAP_PERIOD = 1 + SETTLE + CLEN + 1;
  localparam logic [DW-1:0] PAT_R = 14'h2AAA;
  localparam logic [DW-1:0] PAT_F = 14'h1555;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_rise, data_fall;
  logic          train_start, swap_ch, twos_comp;
  logic [TW-1:0] tap_value;
  logic          tap_load;
  logic [DW-1:0] ch_a_data, ch_b_data;
  logic          data_valid, locked, train_fail, busy;

  lvds_ddr_rx_align #(
    .DATA_WIDTH(DW), .TAP_WIDTH(TW), .SETTLE_CYCLES(SETTLE), .CHECK_LEN(CLEN),
    .PATTERN_RISE(PAT_R), .PATTERN_FALL(PAT_F)
  ) dut (
    .clk(clk), .rst(rst), .data_rise(data_rise), .data_fall(data_fall),
    .train_start(train_start), .swap_ch(swap_ch), .twos_comp(twos_comp),
    .tap_value(tap_value), .tap_load(tap_load), .ch_a_data(ch_a_data),
    .ch_b_data(ch_b_data), .data_valid(data_valid), .locked(locked),
    .train_fail(train_fail), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sweep model: taps are tried from 0 upward; stop after the first bad tap
  // following a good run, or after the top tap.
  function automatic void model(input logic [31:0] good, output int n_sweep,
                                output int center, output bit fail);
    int first = -1;
    int last  = -1;
    n_sweep = 0;
    for (int t = 0; t < 32; t++) begin
      n_sweep++;
      if (good[t]) begin
        if (first < 0) first = t;
        last = t;
      end else if (first >= 0) begin
        break;
      end
    end
    fail   = (first < 0);
    center = fail ? 0 : (first + last) / 2;
  endfunction

  function automatic logic [31:0] mask_range(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int t = lo; t <= hi; t++) m[t] = 1'b1;
    return m;
  endfunction

  // Eye model: correct pattern only at good taps, a corrupted word elsewhere
  logic [31:0] good_mask = '0;
  bit          manual    = 1'b0;
  always @(negedge clk) begin
    if (!manual) begin
      logic [DW-1:0] flip;
      swap_ch   = 1'($urandom);
      twos_comp = 1'($urandom);
      if (good_mask[tap_value] === 1'b1) begin
        data_rise = PAT_R;
        data_fall = PAT_F;
      end else begin
        flip = DW'($urandom_range(1, (1 << DW) - 1));
        if ($urandom_range(0, 1) == 1) begin
          data_rise = PAT_R ^ flip;
          data_fall = PAT_F;
        end else begin
          data_rise = PAT_R;
          data_fall = PAT_F ^ flip;
        end
      end
    end
  end

  // Expected tap_load scoreboard
  typedef struct { int tap; bit first; } load_t;
  load_t exp_loads[$];
  int    cyc = 0;
  int    last_load_cyc = 0;
  int    run_loads = 0;
  bit    cmp_en = 1'b0;

  // Per-cycle compare: datapath against the input words seen at the edge,
  // tap_load pulses against the scoreboard (value and spacing)
  always begin
    logic          s_rst, s_swap, s_tc;
    logic [DW-1:0] s_rise, s_fall;
    int            exp_a, exp_b, half;
    load_t         e;
    @(posedge clk);
    cyc++;
    s_rst = rst; s_swap = swap_ch; s_tc = twos_comp;
    s_rise = data_rise; s_fall = data_fall;
    #1;
    if (cmp_en) begin
      half  = s_tc ? (1 << (DW - 1)) : 0;
      exp_a = s_rst ? 0 : (int'(s_swap ? s_fall : s_rise) + half) % (1 << DW);
      exp_b = s_rst ? 0 : (int'(s_swap ? s_rise : s_fall) + half) % (1 << DW);
      check("ch_a_data", ch_a_data, exp_a);
      check("ch_b_data", ch_b_data, exp_b);
      if (tap_load === 1'b1) begin
        if (exp_loads.size() == 0) begin
          check("tap_load_unexpected", tap_load, 0);
        end else begin
          e = exp_loads.pop_front();
          check("tap_load_value", tap_value, e.tap);
          if (!e.first) check("tap_load_spacing", cyc - last_load_cyc, TAP_PERIOD);
          last_load_cyc = cyc;
          run_loads++;
        end
      end
    end
  end

  // Full training run from a given eye mask, checked against the sweep model
  task automatic run_training(input logic [31:0] mask, input bit poke_busy, input bit from_done);
    int n_sweep, center, i;
    bit fail;
    model(mask, n_sweep, center, fail);
    good_mask = mask;
    for (int t = 0; t < n_sweep; t++) exp_loads.push_back('{t, t == 0});
    exp_loads.push_back('{center, 1'b0});
    run_loads = 0;
    @(negedge clk) train_start = 1'b1;
    @(negedge clk) train_start = 1'b0;
    check("busy_after_start", busy, 1);
    if (from_done) begin
      check("locked_drop", locked, 0);
      check("valid_lags_lock", data_valid, 1);
      @(negedge clk);
      check("valid_drop", data_valid, 0);
    end
    i = 0;
    while (busy && i < 1500) begin
      @(negedge clk);
      train_start = poke_busy && (i == 50);
      i++;
    end
    train_start = 1'b0;
    check("train_timeout", busy, 0);
    check("locked", locked, !fail);
    check("train_fail", train_fail, fail);
    check("final_tap", tap_value, center);
    check("load_count", run_loads, n_sweep + 1);
    check("loads_pending", exp_loads.size(), 0);
    check("valid_before_lag", data_valid, 0);
    @(negedge clk);
    check("valid_after_lag", data_valid, !fail);
  endtask

  initial begin
    int ns, ce, i;
    bit fl;
    rst = 1'b1; train_start = 1'b0; swap_ch = 1'b0; twos_comp = 1'b0;
    data_rise = '0; data_fall = '0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tap_value", tap_value, 0);
    check("rst_tap_load", tap_load, 0);
    check("rst_ch_a", ch_a_data, 0);
    check("rst_ch_b", ch_b_data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_fail", train_fail, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_locked", locked, 0);
    check("idle_busy", busy, 0);

    // Pin the sweep model with hand-computed results
    model(mask_range(9, 17), ns, ce, fl);
    check("model_nom_sweep", ns, 19);
    check("model_nom_center", ce, 13);
    model(mask_range(28, 31), ns, ce, fl);
    check("model_top_sweep", ns, 32);
    check("model_top_center", ce, 29);
    model(32'h0, ns, ce, fl);
    check("model_noeye_sweep", ns, 32);
    check("model_noeye_fail", fl, 1);

    // Nominal eye, with a train_start while busy that must be ignored
    run_training(mask_range(9, 17), 1'b1, 1'b0);
    check("nominal_tap", tap_value, 13);

    // Directed datapath after lock
    @(negedge clk);
    manual = 1'b1;
    data_rise = 14'h0000; data_fall = 14'h3FFF; swap_ch = 1'b0; twos_comp = 1'b1;
    @(negedge clk);
    check("dp_tc_ch_a", ch_a_data, 14'h2000);
    check("dp_tc_ch_b", ch_b_data, 14'h1FFF);
    swap_ch = 1'b1; twos_comp = 1'b0;
    @(negedge clk);
    check("dp_swap_ch_a", ch_a_data, 14'h3FFF);
    check("dp_swap_ch_b", ch_b_data, 14'h0000);
    check("dp_valid", data_valid, 1);
    manual = 1'b0;

    // Retrain from DONE with the eye at the top of the range
    run_training(mask_range(28, 31), 1'b0, 1'b1);
    check("top_tap", tap_value, 29);

    // No eye at all
    run_training(32'h0, 1'b0, 1'b0);

    // Abort mid-CHECK at tap 5
    good_mask = mask_range(9, 17);
    for (int t = 0; t < 6; t++) exp_loads.push_back('{t, t == 0});
    run_loads = 0;
    @(negedge clk) train_start = 1'b1;
    @(negedge clk) train_start = 1'b0;
    i = 0;
    while (run_loads < 6 && i < 500) begin
      @(negedge clk);
      i++;
    end
    check("abort_reach_tap5", run_loads, 6);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    exp_loads.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_tap_value", tap_value, 0);
    check("abort_busy", busy, 0);
    check("abort_locked", locked, 0);
    repeat (100) @(negedge clk);
    check("abort_quiet", run_loads, 6);

    // Randomised eyes: contiguous windows and arbitrary bitmaps
    for (int k = 0; k < 8; k++) begin
      logic [31:0] m;
      int lo, hi;
      if (k % 2 == 0) begin
        lo = $urandom_range(0, 31);
        hi = $urandom_range(lo, 31);
        m  = mask_range(lo, hi);
      end else begin
        m = $urandom;
      end
      run_training(m, 1'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
